// File: rtl/vin_pkg.sv
// Shared encodings and helpers for the video-input clip/decimate path.
package vin_pkg;

  localparam logic [1:0] DEC_1 = 2'd0;
  localparam logic [1:0] DEC_2 = 2'd1;
  localparam logic [1:0] DEC_4 = 2'd2;

  localparam logic [1:0] FM_ALL  = 2'd0;
  localparam logic [1:0] FM_EVEN = 2'd1;
  localparam logic [1:0] FM_ODD  = 2'd2;
  localparam logic [1:0] FM_NONE = 2'd3;

  // FIFO entry carries {sof, eol} on top of the pixel word
  localparam int MARK_W = 2;

  function automatic int fifo_entry_w(input int data_width);
    return data_width + MARK_W;
  endfunction

  // Code 3 is folded onto 1:4
  function automatic logic [1:0] dec_norm(input logic [1:0] dec);
    case (dec)
      DEC_1:   return DEC_1;
      DEC_2:   return DEC_2;
      default: return DEC_4;
    endcase
  endfunction

  function automatic logic field_on(input logic [1:0] fm, input logic fld);
    case (fm)
      FM_ALL:  return 1'b1;
      FM_EVEN: return ~fld;
      FM_ODD:  return fld;
      FM_NONE: return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vin_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear and fill count.
module vin_sync_fifo #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   used
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  do_rd, do_wr;

  assign empty = (used == '0);
  assign full  = (used == (ADDR_WIDTH+1)'(DEPTH));
  assign do_rd = rd & ~empty;
  // a read in the same cycle frees the slot a full-FIFO write needs
  assign do_wr = wr & (~full | do_rd);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      used <= used + (ADDR_WIDTH+1)'(do_wr) - (ADDR_WIDTH+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vin_clip_dec.sv
// Video-input clipper: per-frame shadowed window, 1/2/4 decimation, field select,
// line/frame markers and a buffered ready/valid output.
module vin_clip_dec
  import vin_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int CNT_WIDTH       = 12,
  parameter int FIFO_ADDR_WIDTH = 9,
  parameter int AFULL_MARGIN    = 16
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  vs,
  input  logic                  f,
  input  logic                  pixel_de,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  input  logic [CNT_WIDTH-1:0]  s_width,
  input  logic [CNT_WIDTH-1:0]  s_height,
  input  logic [CNT_WIDTH-1:0]  clip_top,
  input  logic [CNT_WIDTH-1:0]  clip_left,
  input  logic [CNT_WIDTH-1:0]  clip_width,
  input  logic [CNT_WIDTH-1:0]  clip_height,
  input  logic [1:0]            hdec,
  input  logic [1:0]            vdec,
  input  logic [1:0]            field_mode,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  fifo_afull,
  output logic                  overflow
);
  localparam int EW    = fifo_entry_w(DATA_WIDTH);
  localparam int CW1   = CNT_WIDTH + 1;
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int THR   = (DEPTH > AFULL_MARGIN) ? DEPTH - AFULL_MARGIN : 0;
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef struct packed {
    logic [CNT_WIDTH-1:0] s_width;
    logic [CNT_WIDTH-1:0] s_height;
    logic [CNT_WIDTH-1:0] top;
    logic [CNT_WIDTH-1:0] left;
    logic [CNT_WIDTH-1:0] width;
    logic [CNT_WIDTH-1:0] height;
    logic [1:0]           hdec;
    logic [1:0]           vdec;
    logic [1:0]           field_mode;
    logic                 fld;
  } shadow_t;

  shadow_t               sh;
  logic                  vs_d0, vs_d1, fs;
  logic [CNT_WIDTH-1:0]  x_cnt, y_cnt;
  logic                  sof_pending;

  assign fs = vs_d0 & ~vs_d1;

  // Sync edge detect, shadow latch and raster counters
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vs_d0 <= 1'b0;
      vs_d1 <= 1'b0;
      sh    <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      vs_d0 <= vs;
      vs_d1 <= vs_d0;
      if (fs) begin
        sh <= '{s_width: s_width, s_height: s_height, top: clip_top, left: clip_left,
                width: clip_width, height: clip_height, hdec: dec_norm(hdec),
                vdec: dec_norm(vdec), field_mode: field_mode, fld: f};
        x_cnt <= ONE;
        y_cnt <= ONE;
      end else if (pixel_de) begin
        if (x_cnt >= sh.s_width) begin
          x_cnt <= ONE;
          y_cnt <= (y_cnt >= sh.s_height) ? ONE : y_cnt + ONE;
        end else begin
          x_cnt <= x_cnt + ONE;
        end
      end
    end
  end

  // Window, decimation phase and end-of-line test; bounds widened so left+width cannot wrap
  logic [CW1-1:0]       x_w, y_w, left_w, top_w, right_w, bot_w, hstep;
  logic [CNT_WIDTH-1:0] hmask, vmask, x_off, y_off;
  logic                 in_win, dec_ok, keep, eol;

  assign x_w     = {1'b0, x_cnt};
  assign y_w     = {1'b0, y_cnt};
  assign left_w  = {1'b0, sh.left};
  assign top_w   = {1'b0, sh.top};
  assign right_w = left_w + {1'b0, sh.width};
  assign bot_w   = top_w + {1'b0, sh.height};
  assign hmask   = ~({CNT_WIDTH{1'b1}} << sh.hdec);
  assign vmask   = ~({CNT_WIDTH{1'b1}} << sh.vdec);
  assign hstep   = CW1'(1) << sh.hdec;
  assign x_off   = x_cnt - sh.left - ONE;
  assign y_off   = y_cnt - sh.top - ONE;

  assign in_win = (x_w > left_w) && (x_w <= right_w) && (y_w > top_w) && (y_w <= bot_w);
  assign dec_ok = ((x_off & hmask) == '0) && ((y_off & vmask) == '0);
  assign keep   = pixel_de & ~fs & in_win & dec_ok & field_on(sh.field_mode, sh.fld);
  assign eol    = (x_w + hstep) > right_w;

  logic                  kept_q, eol_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      kept_q <= 1'b0;
      eol_q  <= 1'b0;
      data_q <= '0;
    end else begin
      kept_q <= keep;
      eol_q  <= eol;
      data_q <= pixel_data;
    end
  end

  logic [EW-1:0]              head;
  logic                       full, empty, rd, wr_ok;
  logic [FIFO_ADDR_WIDTH:0]   used;

  assign rd    = out_valid & out_ready;
  assign wr_ok = kept_q & (~full | rd) & ~fs;

  vin_sync_fifo #(.ADDR_WIDTH(FIFO_ADDR_WIDTH), .DATA_WIDTH(EW)) u_fifo (
    .clk   (pixel_clk),
    .rst   (rst),
    .clr   (fs),
    .wr    (kept_q),
    .wdata ({sof_pending, eol_q, data_q}),
    .rd    (rd),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .used  (used)
  );

  // sof rides on whichever kept pixel first lands in the FIFO after frame start
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      sof_pending <= 1'b0;
      overflow    <= 1'b0;
      fifo_afull  <= 1'b0;
    end else begin
      fifo_afull <= (used >= (FIFO_ADDR_WIDTH+1)'(THR));
      if (fs) begin
        sof_pending <= 1'b1;
        overflow    <= 1'b0;
      end else begin
        if (wr_ok) sof_pending <= 1'b0;
        if (kept_q && full && !rd) overflow <= 1'b1;
      end
    end
  end

  assign out_valid = ~empty;
  assign {out_sof, out_eol, out_data} = out_valid ? head : '0;

endmodule

// File: tb/tb_vin_clip_dec.sv
// Randomized self-checking bench for vin_clip_dec against a raster-walk reference model.
module tb_vin_clip_dec;
  localparam int DW = 16;
  localparam int CW = 12;

  typedef struct packed {
    logic          sof;
    logic          eol;
    logic [DW-1:0] data;
  } beat_t;

  logic pixel_clk = 1'b0;
  logic rst = 1'b1, vs = 1'b0, f = 1'b0, pixel_de = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] pixel_data = '0;
  logic [CW-1:0] s_width = '0, s_height = '0, clip_top = '0, clip_left = '0;
  logic [CW-1:0] clip_width = '0, clip_height = '0;
  logic [1:0]    hdec = '0, vdec = '0, field_mode = '0;
  logic          out_valid, out_sof, out_eol, fifo_afull, overflow;
  logic [DW-1:0] out_data;

  vin_clip_dec #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_ADDR_WIDTH(3), .AFULL_MARGIN(2)) dut (
    .pixel_clk(pixel_clk), .rst(rst), .vs(vs), .f(f), .pixel_de(pixel_de),
    .pixel_data(pixel_data), .s_width(s_width), .s_height(s_height),
    .clip_top(clip_top), .clip_left(clip_left), .clip_width(clip_width),
    .clip_height(clip_height), .hdec(hdec), .vdec(vdec), .field_mode(field_mode),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .fifo_afull(fifo_afull), .overflow(overflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  int total = 0, bad = 0;
  beat_t got[$], exp[$];
  logic [DW-1:0] pix [1:16][1:16];
  bit   bp_en = 0, chk_stall = 0, stall_prev = 0;
  beat_t stall_beat;
  int   stall_viol = 0;

  // Collect accepted beats and watch for head changes during a stall
  always @(negedge pixel_clk) begin
    if (chk_stall && stall_prev && (!out_valid || beat_t'({out_sof, out_eol, out_data}) !== stall_beat))
      stall_viol++;
    if (out_valid && out_ready) got.push_back(beat_t'({out_sof, out_eol, out_data}));
    stall_prev = out_valid && !out_ready;
    stall_beat = beat_t'({out_sof, out_eol, out_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time=%0t limit=500000", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pixel_clk);
    #1;
  endtask

  task automatic step_bp();
    if (bp_en) out_ready = 1'($urandom_range(1));
    tick(1);
  endtask

  task automatic set_geom(input int sw, input int sh, input int l, input int t, input int w,
                          input int h, input int hd, input int vd, input int fm);
    s_width = CW'(sw); s_height = CW'(sh); clip_left = CW'(l); clip_top = CW'(t);
    clip_width = CW'(w); clip_height = CW'(h); hdec = 2'(hd); vdec = 2'(vd);
    field_mode = 2'(fm);
  endtask

  task automatic start_frame(input logic fv);
    f = fv; vs = 1'b1;
    tick(3);
    vs = 1'b0;
    tick(1);
  endtask

  task automatic send_frame(input int sw, input int sh, input int de_pct, input int n_max,
                            input int mid_idx, input int mid_left);
    int n = 0;
    for (int y = 1; y <= sh; y++)
      for (int x = 1; x <= sw; x++)
        if (n < n_max) begin
          if (n == mid_idx) clip_left = CW'(mid_left);
          while (int'($urandom_range(99)) >= de_pct) begin
            pixel_de = 1'b0;
            step_bp();
          end
          pixel_de = 1'b1;
          pixel_data = DW'($urandom);
          pix[y][x] = pixel_data;
          step_bp();
          n++;
        end
    pixel_de = 1'b0;
  endtask

  // Reference: walk the raster and apply the window / phase / field rules directly
  task automatic model(input int sw, input int sh, input int l, input int t, input int w,
                       input int h, input int hd, input int vd, input int fm, input int fv);
    int hs, vsp;
    bit first, fld_ok;
    beat_t b;
    hs  = 1 << ((hd == 3) ? 2 : hd);
    vsp = 1 << ((vd == 3) ? 2 : vd);
    fld_ok = (fm == 0) || (fm == 1 && fv == 0) || (fm == 2 && fv == 1);
    first = 1;
    exp.delete();
    for (int y = 1; y <= sh; y++)
      for (int x = 1; x <= sw; x++)
        if (fld_ok && x > l && x <= l + w && y > t && y <= t + h &&
            (x - l - 1) % hs == 0 && (y - t - 1) % vsp == 0) begin
          b.sof = first; b.eol = (x + hs > l + w); b.data = pix[y][x];
          exp.push_back(b);
          first = 0;
        end
  endtask

  task automatic test_reset();
    tick(3);
    @(negedge pixel_clk);
    total++;
    if ({out_valid, out_sof, out_eol, out_data, fifo_afull, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b s=%b e=%b d=%h af=%b ov=%b want all 0",
               out_valid, out_sof, out_eol, out_data, fifo_afull, overflow);
    end
    rst = 1'b0; out_ready = 1'b1;
    set_geom(8, 4, 0, 0, 8, 4, 0, 0, 0);
    tick(1);
    got.delete();
    send_frame(8, 4, 100, 20, -1, 0);
    tick(10);
    total++;
    if (got.size() != 0) begin
      bad++;
      $display("FAIL reset_no_fs_output got=%0d beats want=0", got.size());
    end
  endtask

  task automatic test_basic();
    int ns = 0, ne = 0;
    set_geom(8, 4, 2, 1, 4, 2, 0, 0, 0);
    got.delete();
    start_frame(1'b0);
    send_frame(8, 4, 70, 1000, -1, 0);
    tick(20);
    model(8, 4, 2, 1, 4, 2, 0, 0, 0, 0);
    total++;
    if (got.size() != 8 || exp.size() != 8) begin
      bad++;
      $display("FAIL basic_count got=%0d model=%0d want=8", got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL basic_beat[%0d] got=%h want=%h", i, got[i], exp[i]);
      end
      ns += int'(got[i].sof);
      ne += int'(got[i].eol);
    end
    total++;
    if (ns != 1 || ne != 2) begin
      bad++;
      $display("FAIL basic_markers got sof=%0d eol=%0d want sof=1 eol=2", ns, ne);
    end
  endtask

  task automatic test_decimation();
    set_geom(8, 4, 2, 1, 4, 2, 1, 1, 0);
    got.delete();
    start_frame(1'b0);
    send_frame(8, 4, 60, 1000, -1, 0);
    tick(20);
    model(8, 4, 2, 1, 4, 2, 1, 1, 0, 0);
    total++;
    if (got.size() != 2 || exp.size() != 2) begin
      bad++;
      $display("FAIL dec_count got=%0d model=%0d want=2", got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL dec_beat[%0d] got=%h want=%h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_field();
    set_geom(8, 4, 2, 1, 4, 2, 0, 0, 1);
    got.delete();
    start_frame(1'b1);
    send_frame(8, 4, 100, 1000, -1, 0);
    tick(20);
    total++;
    if (got.size() != 0) begin
      bad++;
      $display("FAIL field_odd_excluded got=%0d beats want=0", got.size());
    end
    got.delete();
    start_frame(1'b0);
    send_frame(8, 4, 80, 1000, -1, 0);
    tick(20);
    model(8, 4, 2, 1, 4, 2, 0, 0, 1, 0);
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL field_even_count got=%0d want=%0d", got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL field_even_beat[%0d] got=%h want=%h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    set_geom(12, 2, 0, 0, 12, 1, 0, 0, 0);
    start_frame(1'b0);
    for (int k = 1; k <= 12; k++) begin
      pixel_de = 1'b1;
      pixel_data = DW'($urandom);
      pix[1][k] = pixel_data;
      tick(1);
      pixel_de = 1'b0;
      tick(4);
      @(negedge pixel_clk);
      total++;
      if (fifo_afull !== ((k > 8 ? 8 : k) >= 6)) begin
        bad++;
        $display("FAIL ovf_afull k=%0d got=%b want=%b", k, fifo_afull, ((k > 8 ? 8 : k) >= 6));
      end
      total++;
      if (overflow !== (k > 8)) begin
        bad++;
        $display("FAIL ovf_flag k=%0d got=%b want=%b", k, overflow, (k > 8));
      end
    end
    total++;
    if (!out_valid || out_data !== pix[1][1] || !out_sof) begin
      bad++;
      $display("FAIL ovf_head got v=%b d=%h sof=%b want v=1 d=%h sof=1",
               out_valid, out_data, out_sof, pix[1][1]);
    end
    start_frame(1'b0);
    tick(2);
    @(negedge pixel_clk);
    total++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || fifo_afull !== 1'b0) begin
      bad++;
      $display("FAIL ovf_fs_clear got v=%b ov=%b af=%b want 0 0 0", out_valid, overflow, fifo_afull);
    end
  endtask

  task automatic test_mid_change();
    out_ready = 1'b1;
    tick(1);
    set_geom(8, 4, 2, 1, 4, 2, 0, 0, 0);
    got.delete();
    start_frame(1'b0);
    send_frame(8, 4, 80, 1000, 12, 1);
    tick(20);
    model(8, 4, 2, 1, 4, 2, 0, 0, 0, 0);
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL mid_old_count got=%0d want=%0d", got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL mid_old_beat[%0d] got=%h want=%h", i, got[i], exp[i]);
      end
    end
    got.delete();
    start_frame(1'b0);
    send_frame(8, 4, 80, 1000, -1, 0);
    tick(20);
    model(8, 4, 1, 1, 4, 2, 0, 0, 0, 0);
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL mid_new_count got=%0d want=%0d", got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL mid_new_beat[%0d] got=%h want=%h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_geom(16, 6, 1, 0, 13, 6, 3, 0, 0);
    got.delete();
    start_frame(1'b0);
    stall_viol = 0; chk_stall = 1; bp_en = 1;
    send_frame(16, 6, 25, 1000, -1, 0);
    repeat (40) step_bp();
    bp_en = 0; out_ready = 1'b1;
    tick(20);
    chk_stall = 0;
    model(16, 6, 1, 0, 13, 6, 3, 0, 0, 0);
    total++;
    if (got.size() != exp.size()) begin
      bad++;
      $display("FAIL bp_count got=%0d want=%0d", got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL bp_beat[%0d] got=%h want=%h", i, got[i], exp[i]);
      end
    end
    total++;
    if (stall_viol != 0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_stall_stable got viol=%0d ov=%b want 0 0", stall_viol, overflow);
    end
    // Reset in the middle of a backpressured line
    start_frame(1'b0);
    bp_en = 1;
    send_frame(16, 6, 60, 20, -1, 0);
    bp_en = 0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick(1);
    @(negedge pixel_clk);
    total++;
    if ({out_valid, out_sof, out_eol, out_data, fifo_afull, overflow} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs got v=%b s=%b e=%b d=%h af=%b ov=%b want all 0",
               out_valid, out_sof, out_eol, out_data, fifo_afull, overflow);
    end
    tick(1);
    rst = 1'b0; out_ready = 1'b1;
    got.delete();
    send_frame(16, 6, 100, 30, -1, 0);
    tick(10);
    total++;
    if (got.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_ignored got=%0d beats v=%b want 0 beats v=0", got.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decimation();
    test_field();
    test_overflow();
    test_mid_change();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
